// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered AXI-Stream slice: full throughput, outputs held while stalled.
module axis_reg_slice #(
  parameter int PAYLOAD_W = 11
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 out_ready
);

  logic                 valid_r;
  logic [PAYLOAD_W-1:0] payload_r;
  logic                 load_s;

  // The entry can take a new beat when empty or when it drains in the same cycle.
  assign in_ready    = !valid_r || out_ready;
  assign load_s      = in_valid && in_ready;
  assign out_valid   = valid_r;
  assign out_payload = payload_r;

  // Slice storage: load wins over drain so back-to-back beats keep valid high.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      valid_r   <= 1'b0;
      payload_r <= '0;
    end else if (load_s) begin
      valid_r   <= 1'b1;
      payload_r <= in_payload;
    end else if (out_ready) begin
      valid_r   <= 1'b0;
    end else begin
      valid_r   <= valid_r;
    end
  end

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// Round-robin AXI-Stream arbiter that holds each grant for a whole packet
// and forwards beats through a registered output slice.
module axis_rr_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [ID_W-1:0]           m_axis_tid,
  input  logic                      m_axis_tready,
  output logic [15:0]               pkt_done_cnt
);

  localparam int PAYLOAD_W = DATA_W + 1 + ID_W;

  generate
    if (ID_W != clog2(NUM_SRC)) begin : g_id_w_check
      $error("axis_rr_pkt_arbiter: ID_W must equal clog2(NUM_SRC)");
    end
  endgenerate

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
    return ID_W'((int'(base) + offset) % NUM_SRC);
  endfunction

  logic [1:0]           rst_sync_r;
  logic                 rst_s;
  arb_state_e           state_r, state_s;
  logic [ID_W-1:0]      grant_r, grant_s;
  logic [ID_W-1:0]      rr_ptr_r, rr_ptr_s;
  logic [15:0]          cnt_r, cnt_s;
  logic [ID_W-1:0]      winner_s;
  logic [DATA_W-1:0]    sel_data_s;
  logic                 sel_valid_s;
  logic                 sel_last_s;
  logic                 load_s;
  logic                 slice_ready_s;
  logic                 accept_s;
  logic                 slice_valid_s;
  logic [PAYLOAD_W-1:0] slice_payload_s;

  // Reset asserts immediately but releases two clocks after areset falls.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rst_sync_r <= 2'b11;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b0};
    end
  end
  assign rst_s = rst_sync_r[1];

  // Round-robin search: walking down from the far end lets the nearest requester win.
  always_comb begin
    winner_s = rr_ptr_r;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      winner_s = s_axis_tvalid[rr_index(rr_ptr_r, k)] ? rr_index(rr_ptr_r, k) : winner_s;
    end
  end

  // Granted-source mux and per-source ready.
  always_comb begin
    sel_data_s    = '0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data_s       = (grant_r == ID_W'(i)) ? s_axis_tdata[i*DATA_W +: DATA_W] : sel_data_s;
      s_axis_tready[i] = (state_r == ST_LOCK) && (grant_r == ID_W'(i)) && slice_ready_s;
    end
  end

  assign sel_valid_s = s_axis_tvalid[grant_r];
  assign sel_last_s  = s_axis_tlast[grant_r];
  assign load_s      = (state_r == ST_LOCK) && sel_valid_s;
  assign accept_s    = load_s && slice_ready_s;

  // Next-state, grant, pointer and packet counter.
  always_comb begin
    state_s  = state_r;
    grant_s  = grant_r;
    rr_ptr_s = rr_ptr_r;
    cnt_s    = cnt_r;
    case (state_r)
      ST_ARB: begin
        if (|s_axis_tvalid) begin
          grant_s = winner_s;
          state_s = ST_LOCK;
        end else begin
          state_s = ST_ARB;
        end
      end
      ST_LOCK: begin
        if (accept_s && sel_last_s) begin
          state_s  = ST_ARB;
          rr_ptr_s = (grant_r == ID_W'(NUM_SRC - 1)) ? '0 : grant_r + ID_W'(1);
          cnt_s    = cnt_r + 16'd1;
        end else begin
          state_s = ST_LOCK;
        end
      end
      default: begin
        state_s = ST_ARB;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge aclk or posedge rst_s) begin
    if (rst_s) begin
      state_r  <= ST_ARB;
      grant_r  <= '0;
      rr_ptr_r <= '0;
      cnt_r    <= 16'd0;
    end else begin
      state_r  <= state_s;
      grant_r  <= grant_s;
      rr_ptr_r <= rr_ptr_s;
      cnt_r    <= cnt_s;
    end
  end

  axis_reg_slice #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_out_slice (
    .clk        (aclk),
    .areset     (rst_s),
    .in_valid   (load_s),
    .in_payload ({sel_last_s, grant_r, sel_data_s}),
    .in_ready   (slice_ready_s),
    .out_valid  (slice_valid_s),
    .out_payload(slice_payload_s),
    .out_ready  (m_axis_tready)
  );

  assign m_axis_tvalid = slice_valid_s;
  assign m_axis_tlast  = slice_payload_s[PAYLOAD_W-1];
  assign m_axis_tid    = slice_payload_s[DATA_W +: ID_W];
  assign m_axis_tdata  = slice_payload_s[DATA_W-1:0];
  assign pkt_done_cnt  = cnt_r;

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Randomized bench for axis_rr_pkt_arbiter against a cycle-level behavioural model.
module tb_axis_rr_pkt_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

  logic                      aclk = 1'b0;
  logic                      areset = 1'b0;
  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tlast;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tlast;
  logic [ID_W-1:0]           m_axis_tid;
  logic                      m_axis_tready;
  logic [15:0]               pkt_done_cnt;

  int checks = 0;
  int errors = 0;

  // Source generators: each source owns a current beat and the beats left in its packet.
  logic [DATA_W-1:0] src_data [NUM_SRC];
  int                src_left [NUM_SRC];
  int                valid_pct;
  int                ready_pct;
  int                fixed_len;

  // Reference model: owner < 0 means the arbiter is choosing, else the locked source.
  int                owner;
  int                ptr;
  bit                mv;
  bit                ml;
  logic [DATA_W-1:0] md;
  int                mid;
  logic [15:0]       cnt;
  int                last_ids[$];

  always #5 aclk = ~aclk;

  axis_rr_pkt_arbiter #(
    .NUM_SRC(NUM_SRC),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tready(m_axis_tready),
    .pkt_done_cnt (pkt_done_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int new_len();
    return (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
  endfunction

  function automatic void model_reset();
    owner = -1;
    ptr   = 0;
    mv    = 1'b0;
    ml    = 1'b0;
    md    = '0;
    mid   = 0;
    cnt   = 16'd0;
  endfunction

  task automatic run_cycle(input bit quiet);
    bit                 vld [NUM_SRC];
    bit                 lst [NUM_SRC];
    logic [NUM_SRC-1:0] exp_ready;
    bit                 accept;
    bit                 acc_last;
    int                 acc_src;
    bit                 found;
    int                 idx;
    @(negedge aclk);
    for (int i = 0; i < NUM_SRC; i++) begin
      vld[i] = !quiet && (int'($urandom_range(0, 99)) < valid_pct);
      lst[i] = (src_left[i] == 1);
      s_axis_tvalid[i] = vld[i];
      s_axis_tlast[i]  = lst[i];
      s_axis_tdata[i*DATA_W +: DATA_W] = src_data[i];
    end
    m_axis_tready = (int'($urandom_range(0, 99)) < ready_pct);
    #1;
    exp_ready = '0;
    accept    = 1'b0;
    acc_src   = owner;
    acc_last  = 1'b0;
    if (owner >= 0) begin
      exp_ready[owner] = !mv || m_axis_tready;
      accept           = vld[owner] && exp_ready[owner];
      acc_last         = lst[owner];
    end
    chk("s_tready", 32'(s_axis_tready), 32'(exp_ready));
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(mv));
    if (mv) begin
      chk("m_tdata", 32'(m_axis_tdata), 32'(md));
      chk("m_tlast", 32'(m_axis_tlast), 32'(ml));
      chk("m_tid", 32'(m_axis_tid), 32'(mid));
    end
    chk("pkt_cnt", 32'(pkt_done_cnt), 32'(cnt));
    @(posedge aclk);
    if (accept) begin
      mv  = 1'b1;
      md  = src_data[acc_src];
      ml  = acc_last;
      mid = acc_src;
      if (acc_last) last_ids.push_back(acc_src);
    end else if (m_axis_tready) begin
      mv = 1'b0;
    end
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = (ptr + k) % NUM_SRC;
        if (!found && vld[idx]) begin
          found = 1'b1;
          owner = idx;
        end
      end
    end else if (accept && acc_last) begin
      ptr   = (owner + 1) % NUM_SRC;
      cnt   = cnt + 16'd1;
      owner = -1;
    end
    if (accept) begin
      src_data[acc_src] = DATA_W'($urandom);
      src_left[acc_src] = src_left[acc_src] - 1;
      if (src_left[acc_src] == 0) src_left[acc_src] = new_len();
    end
  endtask

  task automatic apply_reset(input bit mid_run);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    if (mid_run) begin
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_cnt", 32'(pkt_done_cnt), 32'd0);
    end
    model_reset();
    s_axis_tvalid = '0;
    repeat (2) @(negedge aclk);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tid", 32'(m_axis_tid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tvalid_hold", 32'(m_axis_tvalid), 32'd0);
    areset = 1'b0;
    repeat (3) run_cycle(1'b1);
  endtask

  initial begin
    int fair_exp [5];
    fair_exp = '{0, 1, 2, 3, 0};
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
    valid_pct = 100;
    ready_pct = 100;
    fixed_len = 2;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i] = DATA_W'($urandom);
      src_left[i] = 2;
    end
    model_reset();
    #2;
    apply_reset(1'b0);

    // Every source keeps a two-beat packet pending and the sink never stalls.
    last_ids.delete();
    repeat (20) run_cycle(1'b0);
    chk("fair_npkts", 32'(last_ids.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < last_ids.size()) chk("fair_order", 32'(last_ids[i]), 32'(fair_exp[i]));
    end

    fixed_len = 0;
    valid_pct = 70;
    ready_pct = 60;
    repeat (600) run_cycle(1'b0);
    apply_reset(1'b1);

    valid_pct = 40;
    ready_pct = 90;
    repeat (600) run_cycle(1'b0);

    valid_pct = 85;
    ready_pct = 30;
    repeat (600) run_cycle(1'b0);
    apply_reset(1'b1);

    valid_pct = 25;
    ready_pct = 100;
    repeat (300) run_cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
